// File: rtl/measurement_frame_loader.sv
// Ingress parser for the decoder: consumes the host byte stream, recognises the start/header
// protocol and assembles one padded syndrome frame into an unpadded measurement vector.
module measurement_frame_loader #(
  parameter int GRID_WIDTH_X = 20,
  parameter int GRID_WIDTH_Z = 10,
  parameter int GRID_WIDTH_U = 19,
  parameter logic [7:0] START_MSG = 8'h01,
  parameter logic [7:0] MEAS_HDR  = 8'h02,
  localparam int PPR         = GRID_WIDTH_X * GRID_WIDTH_Z,
  localparam int BPR         = (PPR + 7) >> 3,
  localparam int FRAME_BYTES = BPR * GRID_WIDTH_U,
  localparam int CNT_W       = $clog2(FRAME_BYTES + 1),
  localparam int MEAS_W      = PPR * GRID_WIDTH_U
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [MEAS_W-1:0] measurements,
  output logic              meas_valid,
  input  logic              meas_ready,
  output logic              decoding_on,
  output logic              hdr_error,
  output logic [15:0]       frame_count
);

  typedef enum logic [1:0] {IDLE, WAIT_HDR, LOAD, HANDOFF} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] byte_cnt;
  logic             accept;
  logic             last_byte;
  logic             hdr_accept;

  assign accept     = in_valid && in_ready;
  assign last_byte  = (byte_cnt == CNT_W'(FRAME_BYTES - 1));
  assign hdr_accept = (state == WAIT_HDR) && accept && (in_data == MEAS_HDR);
  assign meas_valid = (state == HANDOFF);

  // Padded stream position of unpadded measurement bit i (round-aligned byte padding).
  function automatic int pad_pos(input int i);
    return (i / PPR) * BPR * 8 + (i % PPR);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept && in_data == START_MSG) state_next = WAIT_HDR;
      WAIT_HDR: if (hdr_accept)                     state_next = LOAD;
      LOAD:     if (accept && last_byte)            state_next = HANDOFF;
      HANDOFF:  if (meas_ready)                     state_next = WAIT_HDR;
      default:                                      state_next = IDLE;
    endcase
  end

  // in_ready is registered from the next state so it never depends on in_valid combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready    <= 1'b0;
      decoding_on <= 1'b0;
      hdr_error   <= 1'b0;
      frame_count <= 16'd0;
      byte_cnt    <= '0;
    end else begin
      in_ready  <= (state_next != HANDOFF);
      hdr_error <= (state == WAIT_HDR) && accept &&
                   (in_data != MEAS_HDR) && (in_data != START_MSG);
      if (state == IDLE && accept && in_data == START_MSG) decoding_on <= 1'b1;
      if (state == HANDOFF && meas_ready) frame_count <= frame_count + 16'd1;
      if (hdr_accept)                        byte_cnt <= '0;
      else if (state == LOAD && accept)      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

  // Each measurement bit is loaded from the one stream byte that carries it; pad bits fall through.
  always_ff @(posedge clk) begin
    if (reset || hdr_accept) begin
      measurements <= '0;
    end else if (state == LOAD && accept) begin
      for (int i = 0; i < MEAS_W; i++) begin
        if (byte_cnt == CNT_W'(pad_pos(i) / 8))
          measurements[i] <= in_data[3'(pad_pos(i) % 8)];
      end
    end
  end

endmodule

// File: tb/tb_measurement_frame_loader.sv
// Directed bench for measurement_frame_loader with a 4x1x3 grid (one byte per round, 12-bit frame).
module tb_measurement_frame_loader;

  localparam int MW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] measurements;
  logic          meas_valid;
  logic          meas_ready;
  logic          decoding_on;
  logic          hdr_error;
  logic [15:0]   frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  measurement_frame_loader #(
    .GRID_WIDTH_X(4),
    .GRID_WIDTH_Z(1),
    .GRID_WIDTH_U(3),
    .START_MSG   (8'h01),
    .MEAS_HDR    (8'h02)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .measurements(measurements),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .decoding_on (decoding_on),
    .hdr_error   (hdr_error),
    .frame_count (frame_count)
  );

  typedef struct {
    logic [7:0]    d;
    logic          v;
    logic          mr;
    logic          ir;
    logic          mv;
    logic [MW-1:0] m;
    logic          don;
    logic          he;
    logic [15:0]   fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] d, input logic v, input logic mr,
                              input logic ir, input logic mv, input logic [MW-1:0] m,
                              input logic don, input logic he, input logic [15:0] fc);
    vec_t r;
    r.d = d; r.v = v; r.mr = mr; r.ir = ir; r.mv = mv; r.m = m;
    r.don = don; r.he = he; r.fc = fc;
    return r;
  endfunction

  task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ir, input logic mv,
                           input logic [MW-1:0] m, input logic don, input logic he,
                           input logic [15:0] fc);
    chk1({tag, " in_ready"},     32'(in_ready),     32'(ir));
    chk1({tag, " meas_valid"},   32'(meas_valid),   32'(mv));
    chk1({tag, " measurements"}, 32'(measurements), 32'(m));
    chk1({tag, " decoding_on"},  32'(decoding_on),  32'(don));
    chk1({tag, " hdr_error"},    32'(hdr_error),    32'(he));
    chk1({tag, " frame_count"},  32'(frame_count),  32'(fc));
  endtask

  // Apply one cycle of inputs; outputs are observed 1 time unit after the edge.
  task automatic step(input logic [7:0] d, input logic v, input logic mr);
    in_data    = d;
    in_valid   = v;
    meas_ready = mr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    in_data    = 8'h01;
    in_valid   = 1'b1;
    meas_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;

    // idle, junk before start, basic frame
    vecs.push_back(mk(8'h00, 0, 0, 1, 0, 12'h000, 0, 0, 16'd0));
    vecs.push_back(mk(8'h02, 1, 0, 1, 0, 12'h000, 0, 0, 16'd0));
    vecs.push_back(mk(8'h33, 1, 0, 1, 0, 12'h000, 0, 0, 16'd0));
    vecs.push_back(mk(8'h01, 1, 0, 1, 0, 12'h000, 1, 0, 16'd0));
    vecs.push_back(mk(8'h02, 1, 0, 1, 0, 12'h000, 1, 0, 16'd0));
    vecs.push_back(mk(8'hFF, 1, 0, 1, 0, 12'h00F, 1, 0, 16'd0));
    vecs.push_back(mk(8'h05, 1, 0, 1, 0, 12'h05F, 1, 0, 16'd0));
    vecs.push_back(mk(8'h0A, 1, 0, 0, 1, 12'hA5F, 1, 0, 16'd0));
    vecs.push_back(mk(8'h00, 0, 1, 1, 0, 12'hA5F, 1, 0, 16'd1));
    // bad header, start byte while waiting, then a frame
    vecs.push_back(mk(8'h7E, 1, 0, 1, 0, 12'hA5F, 1, 1, 16'd1));
    vecs.push_back(mk(8'h00, 0, 0, 1, 0, 12'hA5F, 1, 0, 16'd1));
    vecs.push_back(mk(8'h01, 1, 0, 1, 0, 12'hA5F, 1, 0, 16'd1));
    vecs.push_back(mk(8'h02, 1, 0, 1, 0, 12'h000, 1, 0, 16'd1));
    vecs.push_back(mk(8'h0C, 1, 0, 1, 0, 12'h00C, 1, 0, 16'd1));
    vecs.push_back(mk(8'h0C, 1, 0, 1, 0, 12'h0CC, 1, 0, 16'd1));
    vecs.push_back(mk(8'h0C, 1, 0, 0, 1, 12'hCCC, 1, 0, 16'd1));
    vecs.push_back(mk(8'h00, 0, 1, 1, 0, 12'hCCC, 1, 0, 16'd2));
    // gapped stream, header/start values appearing as data
    vecs.push_back(mk(8'h01, 1, 0, 1, 0, 12'hCCC, 1, 0, 16'd2));
    vecs.push_back(mk(8'h55, 0, 0, 1, 0, 12'hCCC, 1, 0, 16'd2));
    vecs.push_back(mk(8'h02, 1, 0, 1, 0, 12'h000, 1, 0, 16'd2));
    vecs.push_back(mk(8'h55, 0, 0, 1, 0, 12'h000, 1, 0, 16'd2));
    vecs.push_back(mk(8'h02, 1, 0, 1, 0, 12'h002, 1, 0, 16'd2));
    vecs.push_back(mk(8'h55, 0, 0, 1, 0, 12'h002, 1, 0, 16'd2));
    vecs.push_back(mk(8'h01, 1, 0, 1, 0, 12'h012, 1, 0, 16'd2));
    vecs.push_back(mk(8'h55, 0, 0, 1, 0, 12'h012, 1, 0, 16'd2));
    vecs.push_back(mk(8'h02, 1, 0, 0, 1, 12'h212, 1, 0, 16'd2));
    vecs.push_back(mk(8'h55, 0, 0, 0, 1, 12'h212, 1, 0, 16'd2));
    vecs.push_back(mk(8'h55, 0, 1, 1, 0, 12'h212, 1, 0, 16'd3));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].d, vecs[i].v, vecs[i].mr);
      check_out($sformatf("vec%0d", i), vecs[i].ir, vecs[i].mv, vecs[i].m,
                vecs[i].don, vecs[i].he, vecs[i].fc);
    end

    // Backpressure: frame held while the FIFO keeps offering a header byte
    step(8'h02, 1, 0);
    step(8'hFF, 1, 0);
    step(8'h05, 1, 0);
    step(8'h0A, 1, 0);
    check_out("bp_full", 1'b0, 1'b1, 12'hA5F, 1'b1, 1'b0, 16'd3);
    for (int c = 0; c < 10; c++) begin
      step(8'h02, 1, 0);
      check_out($sformatf("bp_hold%0d", c), 1'b0, 1'b1, 12'hA5F, 1'b1, 1'b0, 16'd3);
    end
    step(8'h02, 1, 1);
    check_out("bp_release", 1'b1, 1'b0, 12'hA5F, 1'b1, 1'b0, 16'd4);
    step(8'h02, 1, 0);
    check_out("bp_hdr", 1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 16'd4);
    step(8'h01, 1, 0);
    step(8'h02, 1, 0);
    step(8'h03, 1, 0);
    check_out("bp_frame2", 1'b0, 1'b1, 12'h321, 1'b1, 1'b0, 16'd4);
    step(8'h00, 0, 1);
    check_out("bp_done", 1'b1, 1'b0, 12'h321, 1'b1, 1'b0, 16'd5);

    // Reset in the middle of a frame
    step(8'h02, 1, 0);
    step(8'h0F, 1, 0);
    step(8'h05, 1, 0);
    check_out("rst_partial", 1'b1, 1'b0, 12'h05F, 1'b1, 1'b0, 16'd5);
    reset = 1'b1;
    step(8'h0A, 1, 0);
    check_out("rst_mid", 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    step(8'h00, 0, 0);
    check_out("rst_idle", 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 16'd0);
    step(8'h02, 1, 0);
    step(8'h0F, 1, 0);
    step(8'h05, 1, 0);
    step(8'h0A, 1, 0);
    check_out("rst_ignored", 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 16'd0);
    step(8'h01, 1, 0);
    check_out("rst_start", 1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 16'd0);
    step(8'h02, 1, 0);
    step(8'h0F, 1, 0);
    step(8'h05, 1, 0);
    step(8'h0A, 1, 0);
    check_out("rst_frame", 1'b0, 1'b1, 12'hA5F, 1'b1, 1'b0, 16'd0);
    step(8'h00, 0, 1);
    check_out("rst_done", 1'b1, 1'b0, 12'hA5F, 1'b1, 1'b0, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
